// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] DBZ_QUOT = 8'hFF;

endpackage

// File: rtl/div_step.sv
// One combinational unsigned restoring-division step: shift in the next
// dividend bit, subtract the divisor if it fits, and emit the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_prem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_sh;

    // A non-negative difference is always below the divisor, so it fits in WIDTH bits.
    assign w_sh   = {i_prem, i_bit};
    assign o_qbit = (w_sh >= {1'b0, i_dvs});
    assign o_rem  = o_qbit ? (w_sh[WIDTH-1:0] - i_dvs) : w_sh[WIDTH-1:0];

endmodule

// File: rtl/seq_div_8bit.sv
// Sequential 8-bit unsigned divider: IDLE/RUN/DONE FSM, one restoring step
// per RUN cycle, divide-by-zero short-cut, one-cycle done pulse.
module seq_div_8bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;
    logic             r_zero;
    logic [WIDTH-1:0] w_rem;
    logic             w_qbit;
    logic             w_accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    assign w_accept = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A zero divisor spends a single RUN cycle, so its DONE lands one edge after acceptance.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_zero || (r_cnt == LAST_STEP)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_zero <= (divisor == '0);
            if (divisor != '0) r_dbz <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_zero) begin
                r_quot <= WIDTH'(DBZ_QUOT);
                r_rem  <= r_dvd;
                r_dbz  <= 1'b1;
            end else if (r_cnt == LAST_STEP) begin
                r_quot <= {r_q[WIDTH-2:0], w_qbit};
                r_rem  <= w_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_q    <= '0;
        end else if (r_state == RUN) begin
            r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
            r_prem <= w_rem;
            r_q    <= {r_q[WIDTH-2:0], w_qbit};
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div_8bit.sv
// Directed and randomized bench for seq_div_8bit against an arithmetic
// reference (integer / and %), including timing, reset and divide-by-zero.
module tb_seq_div_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for its done pulse; lat counts
    // falling edges from the accepting edge to the one where done is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit rel,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic z, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        @(negedge clk);
        if (rel) rst = 1'b0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) check("busy_run", busy, 1);
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        q = quot;
        r = rem;
        z = div_by_zero;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy_low", busy, 0);
        check("quot_hold", quot, q);
        check("rem_hold", rem, r);
    endtask

    task automatic expect_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input bit rel);
        logic [7:0] q, r;
        logic       z;
        int         lat;
        run_op(a, b, rel, q, r, z, lat);
        check({tag, "_lat"},  lat, (b == 8'd0) ? 2 : 9);
        check({tag, "_quot"}, q, (b == 8'd0) ? 8'hFF : a / b);
        check({tag, "_rem"},  r, (b == 8'd0) ? a : a % b);
        check({tag, "_dbz"},  z, (b == 8'd0) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] q, r, ea, eb;
        int         ndone, k, exp_k;
        bit         got;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quot, 0);
        check("rst_rem",  rem, 0);
        check("rst_dbz",  div_by_zero, 0);

        // first operation starts on the same falling edge that releases reset
        expect_op("c8_07", 8'hC8, 8'h07, 1'b1);
        expect_op("ff_01", 8'hFF, 8'h01, 1'b0);
        expect_op("05_ff", 8'h05, 8'hFF, 1'b0);
        expect_op("2a_00", 8'h2A, 8'h00, 1'b0);
        expect_op("10_04", 8'h10, 8'h04, 1'b0);

        // start re-pulsed mid-operation must be ignored
        @(negedge clk);
        dividend = 8'h64;
        divisor  = 8'h0A;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        dividend = 8'h09;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        q = 8'h00;
        r = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    q = quot;
                    r = rem;
                end
            end
        end
        check("ignore_start_ndone", ndone, 1);
        check("ignore_start_quot", q, 8'h0A);
        check("ignore_start_rem", r, 8'h00);

        expect_op("7f_05", 8'h7F, 8'h05, 1'b0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        dividend = 8'h3C;
        divisor  = 8'h07;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quot", quot, 0);
        check("midrst_rem",  rem, 0);
        check("midrst_dbz",  div_by_zero, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        expect_op("81_02", 8'h81, 8'h02, 1'b0);

        // back-to-back random operations with start held high
        ea = 8'($urandom_range(0, 255));
        eb = 8'($urandom_range(1, 255));
        @(negedge clk);
        dividend = ea;
        divisor  = eb;
        start    = 1'b1;
        for (int op = 0; op < 200; op++) begin
            got = 1'b0;
            k   = 0;
            for (int i = 0; i < 24 && !got; i++) begin
                @(negedge clk);
                k++;
                if (done) got = 1'b1;
            end
            check("b2b_done", got, 1);
            if (op == 0) exp_k = (eb == 8'd0) ? 2 : 9;
            else         exp_k = (eb == 8'd0) ? 3 : 10;
            check("b2b_interval", k, exp_k);
            check("b2b_quot", quot, (eb == 8'd0) ? 8'hFF : ea / eb);
            check("b2b_rem",  rem, (eb == 8'd0) ? ea : ea % eb);
            check("b2b_dbz",  div_by_zero, (eb == 8'd0) ? 1 : 0);
            if (eb != 8'd0) begin
                check("b2b_identity", int'(quot) * int'(eb) + int'(rem), int'(ea));
                check("b2b_rem_lt_div", (rem < eb) ? 1 : 0, 1);
            end
            ea = 8'($urandom_range(0, 255));
            eb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            dividend = ea;
            divisor  = eb;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div_8bit.md
SEQ_DIV_8BIT -- requirements
Module: seq_div_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; only 8 is required to be supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  8  unsigned dividend; sampled with an accepted start.
REQ-006 SHALL have port divisor  input  8  unsigned divisor; sampled with an accepted start.
REQ-007 SHALL have port busy  output  1  high while in RUN or DONE.
REQ-008 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have port quot  output  8  registered quotient.
REQ-010 SHALL have port rem  output  8  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, registered.
REQ-013 SHALL accept start only when in IDLE; start in RUN or DONE is ignored and operands are not re-sampled.
REQ-014 SHALL, on acceptance at edge N with divisor != 0, latch the operands, clear the 4-bit iteration counter and the partial remainder, and go to RUN.
REQ-015 SHALL perform one unsigned restoring step per cycle in RUN, MSB first: shift {rem,dividend bit}; if the 9-bit difference is non-negative, keep it and set the quotient bit, else restore and clear it.
REQ-016 SHALL complete the 8th step at edge N+8, load quot and rem, and enter DONE.
REQ-017 SHALL hold done=1 for exactly one cycle in DONE, between edges N+8 and N+9, then return to IDLE.
REQ-018 SHALL, on acceptance at edge N with divisor == 0, skip RUN, set quot=8'hFF, rem=dividend and div_by_zero=1, and enter DONE at edge N+1.
REQ-019 SHALL clear div_by_zero on the next accepted start with a non-zero divisor.
REQ-020 SHALL hold quot, rem and div_by_zero stable from done until the next completion.
REQ-021 SHALL guarantee dividend == quot*divisor + rem and rem < divisor for every non-zero divisor.
REQ-022 SHALL accept start high in the same cycle as done at the edge after DONE (IDLE at that edge), giving back-to-back operation every 10 cycles.
REQ-023 SHALL keep busy low only in IDLE.

Reset
REQ-024 SHALL, on rst high, immediately force state=IDLE, counter=0, busy=0, done=0, quot=0, rem=0 and div_by_zero=0, independent of clk.
REQ-025 SHALL abandon an operation in progress when rst is asserted mid-operation, with no done pulse afterwards.
REQ-026 SHALL accept a start at the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the WIDTH default, the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the divide-by-zero quotient constant 8'hFF in the shared package div_pkg.
REQ-028 SHALL isolate one combinational restoring step (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit) in sub-module div_step.
REQ-029 SHALL contain the FSM, counter and result registers in seq_div_8bit, with no other sub-modules.

Verification
REQ-030 SHALL cover: dividend 0xC8, divisor 0x07, start at edge N -> done only in cycle N+8..N+9, quot=0x1C, rem=0x04, div_by_zero=0.
REQ-031 SHALL cover: dividend 0xFF, divisor 0x01 -> quot=0xFF, rem=0x00; then dividend 0x05, divisor 0xFF -> quot=0x00, rem=0x05.
REQ-032 SHALL cover: dividend 0x2A, divisor 0x00 -> done at N+1, quot=0xFF, rem=0x2A, div_by_zero=1; the next 0x10/0x04 -> quot=0x04, rem=0x00, div_by_zero=0.
REQ-033 SHALL cover: start pulsed at N+3 with 0x09/0x03 during a 0x64/0x0A operation -> a single done with quot=0x0A, rem=0x00.
REQ-034 SHALL cover: rst asserted at N+4 of an operation -> all outputs 0 at once, no done pulse, and the next operation 0x81/0x02 returns quot=0x40, rem=0x01.
REQ-035 SHALL cover: 200 random back-to-back operations, each checked against dividend == quot*divisor + rem, with a pass/fail count reported.
